// File: rtl/edge_ser_tx.sv
// edge_ser_tx: serial clock/data transmitter for an edge-sensitive capture
// element. A parallel word is shifted out MSB first. sdata only changes when
// LOW is entered, so it is always stable across every rising edge of sclk.
// Optional feature: define EDGE_SER_TX_PARITY_EN to append one even-parity
// bit (XOR of the accepted word) after the payload bits.
module edge_ser_tx #(
   parameter int WIDTH = 8,
   parameter int DIV   = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] din,
   output logic             busy,
   output logic             done,
   output logic             sclk,
   output logic             sdata
);

`ifdef EDGE_SER_TX_PARITY_EN
   localparam int NBITS = WIDTH + 1;
`else
   localparam int NBITS = WIDTH;
`endif

   localparam int PH_W = $clog2(DIV + 1);
   localparam int BC_W = $clog2(WIDTH + 2);
   localparam logic [PH_W-1:0] PH_LAST = PH_W'(DIV - 1);
   localparam logic [BC_W-1:0] BC_LAST = BC_W'(NBITS - 1);

   typedef enum logic [1:0] {
      IDLE,
      LOW,
      HIGH,
      DONE
   } state_t;

   state_t           state;
   state_t           next_state;
   logic [NBITS-1:0] shift_reg;
   logic [NBITS-1:0] load_word;
   logic [PH_W-1:0]  phase_cnt;
   logic [BC_W-1:0]  bit_cnt;
   logic             phase_end;
   logic             last_bit;

`ifdef EDGE_SER_TX_PARITY_EN
   assign load_word = {din, ^din};
`else
   assign load_word = din;
`endif

   assign phase_end = (phase_cnt == PH_LAST);
   assign last_bit  = (bit_cnt == BC_LAST);

   // State register: synchronous reset drops any transfer in progress.
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Shift register and counters: load on acceptance, shift only when leaving HIGH for LOW.
   always_ff @(posedge clock) begin
      if (reset) begin
         shift_reg <= '0;
         phase_cnt <= '0;
         bit_cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  shift_reg <= load_word;
                  phase_cnt <= '0;
                  bit_cnt   <= '0;
               end
            end
            LOW: begin
               if (phase_end) begin
                  phase_cnt <= '0;
               end else begin
                  phase_cnt <= phase_cnt + PH_W'(1);
               end
            end
            HIGH: begin
               if (phase_end) begin
                  phase_cnt <= '0;
                  if (!last_bit) begin
                     shift_reg <= shift_reg << 1;
                     bit_cnt   <= bit_cnt + BC_W'(1);
                  end
               end else begin
                  phase_cnt <= phase_cnt + PH_W'(1);
               end
            end
            default: begin
               phase_cnt <= '0;
            end
         endcase
      end
   end

   // Next-state logic: LOW and HIGH each last DIV cycles; DONE lasts one cycle and ignores start.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (start) begin
               next_state = LOW;
            end
         end
         LOW: begin
            if (phase_end) begin
               next_state = HIGH;
            end
         end
         HIGH: begin
            if (phase_end) begin
               next_state = last_bit ? DONE : LOW;
            end
         end
         DONE: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Output decode: sdata follows the shift register MSB only while a bit is on the wire.
   always_comb begin
      busy  = 1'b0;
      done  = 1'b0;
      sclk  = 1'b0;
      sdata = 1'b0;
      case (state)
         LOW: begin
            busy  = 1'b1;
            sdata = shift_reg[NBITS-1];
         end
         HIGH: begin
            busy  = 1'b1;
            sclk  = 1'b1;
            sdata = shift_reg[NBITS-1];
         end
         DONE: begin
            done = 1'b1;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_edge_ser_tx.sv
// tb_edge_ser_tx: self-checking bench for edge_ser_tx. A main instance
// (WIDTH=8, DIV=2) is checked by a rise-edge scoreboard plus cycle-accurate
// latency checks; a small instance (WIDTH=1, DIV=1) covers the minimum
// configuration. Honors EDGE_SER_TX_PARITY_EN when it is defined.
module tb_edge_ser_tx;

`ifdef EDGE_SER_TX_PARITY_EN
   localparam int NB = 9;
   localparam int NS = 2;
`else
   localparam int NB = 8;
   localparam int NS = 1;
`endif
   localparam int MDIV     = 2;
   localparam int EXP_DONE = 1 + 2 * MDIV * NB;
   localparam int EXP_RISE = 1 + MDIV;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [7:0] din   = 8'h00;
   logic       busy, done, sclk, sdata;

   logic       start_s = 1'b0;
   logic [0:0] din_s   = 1'b0;
   logic       busy_s, done_s, sclk_s, sdata_s;

   int vectors     = 0;
   int miscompares = 0;
   int violations  = 0;

   logic exp_q[$];
   logic prev_sclk  = 1'b0;
   logic prev_sdata = 1'b0;

   typedef struct {
      logic [7:0] din;
      logic [7:0] sent;
      logic       par;
   } vec_t;

   vec_t vecs[7];

   edge_ser_tx #(.WIDTH(8), .DIV(MDIV)) u_dut (
      .clock (clock),
      .reset (reset),
      .start (start),
      .din   (din),
      .busy  (busy),
      .done  (done),
      .sclk  (sclk),
      .sdata (sdata)
   );

   edge_ser_tx #(.WIDTH(1), .DIV(1)) u_small (
      .clock (clock),
      .reset (reset),
      .start (start_s),
      .din   (din_s),
      .busy  (busy_s),
      .done  (done_s),
      .sclk  (sclk_s),
      .sdata (sdata_s)
   );

   // Free-running system clock.
   always #5 clock = ~clock;

   // Watchdog so the run can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, want finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Scoreboard monitor: pop one expected bit per sclk rise, and flag any sdata change while sclk is high.
   always @(negedge clock) begin
      if (!reset) begin
         if (sclk && (sdata !== prev_sdata)) begin
            violations++;
            miscompares++;
            $display("[TB] FAIL sdata_stable at %0t: got change %b->%b with sclk=1, want no change",
                     $time, prev_sdata, sdata);
         end
         if (sclk && !prev_sclk) begin
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("[TB] FAIL rise_unexpected at %0t: got sclk rise, want none", $time);
            end else begin
               logic exp_bit;
               exp_bit = exp_q.pop_front();
               if (sdata !== exp_bit) begin
                  miscompares++;
                  $display("[TB] FAIL rise_bit at %0t: got %b, want %b", $time, sdata, exp_bit);
               end
            end
         end
      end
      prev_sclk  = sclk;
      prev_sdata = sdata;
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic applyStimulus(input logic s, input logic [7:0] d);
      start = s;
      din   = d;
   endtask

   task automatic checkOutput(input string name, input int actual, input int expected);
      vectors++;
      if (actual != expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
      end
   endtask

   // sent[i] is the i-th bit on the wire; parity bit follows when enabled.
   task automatic push_bits(input logic [7:0] sent, input logic par);
      for (int i = 0; i < 8; i++) begin
         exp_q.push_back(sent[i]);
      end
`ifdef EDGE_SER_TX_PARITY_EN
      exp_q.push_back(par);
`else
      if (par) begin
      end
`endif
   endtask

   task automatic run_transfer(input vec_t v);
      int done_cycle = -1;
      int rise_cycle = -1;
      int done_cnt   = 0;
      int busy_err   = 0;
      push_bits(v.sent, v.par);
      applyStimulus(1'b1, v.din);
      tick();
      applyStimulus(1'b0, ~v.din);
      for (int cyc = 1; cyc <= EXP_DONE + 4; cyc++) begin
         if (done) begin
            done_cnt++;
            if (done_cycle < 0) done_cycle = cyc;
         end
         if (sclk && rise_cycle < 0) rise_cycle = cyc;
         if (cyc < EXP_DONE && !busy) busy_err++;
         if (cyc >= EXP_DONE && busy) busy_err++;
         if (cyc == 5) din = 8'h5A;
         tick();
      end
      checkOutput("done_cycle", done_cycle, EXP_DONE);
      checkOutput("first_rise_cycle", rise_cycle, EXP_RISE);
      checkOutput("done_pulses", done_cnt, 1);
      checkOutput("busy_window_errors", busy_err, 0);
      checkOutput("bits_outstanding", exp_q.size(), 0);
   endtask

   initial begin
      int d1, d2, done_cnt, first_done, second_done, small_done;

      vecs[0] = '{din: 8'hA5, sent: 8'hA5, par: 1'b0};
      vecs[1] = '{din: 8'h07, sent: 8'hE0, par: 1'b1};
      vecs[2] = '{din: 8'hFF, sent: 8'hFF, par: 1'b0};
      vecs[3] = '{din: 8'h00, sent: 8'h00, par: 1'b0};
      vecs[4] = '{din: 8'h3C, sent: 8'h3C, par: 1'b0};
      vecs[5] = '{din: 8'h01, sent: 8'h80, par: 1'b1};
      vecs[6] = '{din: 8'hC1, sent: 8'h83, par: 1'b1};

      $display("[TB] reset");
      reset = 1'b1;
      tick();
      tick();
      checkOutput("reset_busy", int'(busy), 0);
      checkOutput("reset_done", int'(done), 0);
      checkOutput("reset_sclk", int'(sclk), 0);
      checkOutput("reset_sdata", int'(sdata), 0);
      reset = 1'b0;
      tick();
      checkOutput("idle_sclk", int'(sclk), 0);
      checkOutput("idle_sdata", int'(sdata), 0);

      $display("[TB] table-driven transfers");
      for (int k = 0; k < 7; k++) begin
         run_transfer(vecs[k]);
      end

      $display("[TB] start held high, din changed mid-transfer");
      d1 = EXP_DONE;
      d2 = d1 + 1 + EXP_DONE;
      done_cnt = 0;
      first_done = -1;
      second_done = -1;
      push_bits(vecs[0].sent, vecs[0].par);
      applyStimulus(1'b1, vecs[0].din);
      tick();
      for (int cyc = 1; cyc <= d2 + 4; cyc++) begin
         if (done) begin
            done_cnt++;
            if (first_done < 0) first_done = cyc;
            else if (second_done < 0) second_done = cyc;
         end
         if (cyc == 10) din = vecs[4].din;
         if (cyc == d1) checkOutput("held_busy_in_done", int'(busy), 0);
         if (cyc == d1 + 1) begin
            checkOutput("held_busy_idle_gap", int'(busy), 0);
            push_bits(vecs[4].sent, vecs[4].par);
         end
         if (cyc == d1 + 2) begin
            checkOutput("held_busy_second", int'(busy), 1);
            start = 1'b0;
         end
         tick();
      end
      checkOutput("held_first_done", first_done, d1);
      checkOutput("held_second_done", second_done, d2);
      checkOutput("held_done_pulses", done_cnt, 2);
      checkOutput("held_bits_outstanding", exp_q.size(), 0);

      $display("[TB] reset mid-transfer");
      push_bits(vecs[2].sent, vecs[2].par);
      applyStimulus(1'b1, vecs[2].din);
      tick();
      applyStimulus(1'b0, vecs[2].din);
      for (int cyc = 1; cyc < 12; cyc++) begin
         tick();
      end
      reset = 1'b1;
      exp_q.delete();
      tick();
      reset = 1'b0;
      checkOutput("abort_sclk", int'(sclk), 0);
      checkOutput("abort_sdata", int'(sdata), 0);
      checkOutput("abort_busy", int'(busy), 0);
      done_cnt = 0;
      for (int cyc = 13; cyc <= 45; cyc++) begin
         if (done) done_cnt++;
         tick();
      end
      checkOutput("abort_done_pulses", done_cnt, 0);
      run_transfer(vecs[5]);

      $display("[TB] WIDTH=1 DIV=1 instance");
      start_s = 1'b1;
      din_s   = 1'b1;
      tick();
      start_s = 1'b0;
      din_s   = 1'b0;
      checkOutput("small_c1_sclk", int'(sclk_s), 0);
      checkOutput("small_c1_sdata", int'(sdata_s), 1);
      checkOutput("small_c1_busy", int'(busy_s), 1);
      tick();
      checkOutput("small_c2_sclk", int'(sclk_s), 1);
      checkOutput("small_c2_sdata", int'(sdata_s), 1);
      small_done = -1;
      for (int cyc = 2; cyc <= 10; cyc++) begin
         if (done_s && small_done < 0) small_done = cyc;
         tick();
      end
      checkOutput("small_done_cycle", small_done, 1 + 2 * NS);

      checkOutput("sdata_stable_violations", violations, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
